// File: rtl/top_riscv_pkg.sv
// Shared decode constants and select types for the top_riscv RV32I core.
// The TOP_RISCV_MUL_EN macro adds the MUL funct7 encoding.
package top_riscv_pkg;
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] word_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef TOP_RISCV_MUL_EN
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
`endif

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB, ALU_MUL
  } alu_op_e;

  typedef enum logic [1:0] {PC_PLUS4, PC_BRANCH, PC_JAL, PC_JALR} pc_sel_e;
  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  function automatic word_t sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction
endpackage

// File: rtl/top_riscv_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// asynchronous clear, x0 reads as zero and ignores writes.
module top_riscv_regfile
  import top_riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] raddr_a_i,
  input  logic [4:0] raddr_b_i,
  output word_t      rdata_a_o,
  output word_t      rdata_b_o,
  input  logic       we_i,
  input  logic [4:0] waddr_i,
  input  word_t      wdata_i
);
  word_t regs_q [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : regs_q[raddr_b_i];
endmodule

// File: rtl/top_riscv.sv
// Single-cycle RV32I core: fetch, decode, execute and memory access in one cycle.
// Define TOP_RISCV_MUL_EN to execute MUL; otherwise that encoding is a NOP.
module top_riscv
  import top_riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] iadrr,
  input  logic [31:0] instr_in,
  output logic [31:0] daddr,
  output logic [31:0] data_out,
  input  logic [31:0] mem_data,
  output logic        mem_en
);
  word_t      pc_q, pc_d, pc_plus4;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  word_t      rs1_val, rs2_val;
  word_t      imm_i_w, imm_s_w, imm_b_w, imm_u_w, imm_j_w;
  word_t      op_a, op_b, alu_res, wb_data;
  alu_op_e    alu_op;
  pc_sel_e    pc_sel;
  wb_sel_e    wb_sel;
  logic       op_a_pc, is_store, br_taken;

  assign opcode = instr_in[6:0];
  assign rd     = instr_in[11:7];
  assign funct3 = instr_in[14:12];
  assign rs1    = instr_in[19:15];
  assign rs2    = instr_in[24:20];
  assign funct7 = instr_in[31:25];

  assign imm_i_w = sext12(instr_in[31:20]);
  assign imm_s_w = sext12({instr_in[31:25], instr_in[11:7]});
  assign imm_b_w = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25],
                    instr_in[11:8], 1'b0};
  assign imm_u_w = {instr_in[31:12], 12'b0};
  assign imm_j_w = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20],
                    instr_in[30:21], 1'b0};

  top_riscv_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .raddr_a_i (rs1),
    .raddr_b_i (rs2),
    .rdata_a_o (rs1_val),
    .rdata_b_o (rs2_val),
    .we_i      (wb_sel != WB_NONE),
    .waddr_i   (rd),
    .wdata_i   (wb_data)
  );

  // Anything not matched below leaves the defaults in place, i.e. a NOP.
  always_comb begin
    alu_op   = ALU_ADD;
    op_a_pc  = 1'b0;
    op_b     = imm_i_w;
    pc_sel   = PC_PLUS4;
    wb_sel   = WB_NONE;
    is_store = 1'b0;
    case (opcode)
      OPC_LUI:    begin alu_op = ALU_PASSB; op_b = imm_u_w; wb_sel = WB_ALU; end
      OPC_AUIPC:  begin op_a_pc = 1'b1; op_b = imm_u_w; wb_sel = WB_ALU; end
      OPC_JAL:    begin pc_sel = PC_JAL; wb_sel = WB_PC4; end
      OPC_JALR:   if (funct3 == F3_ADD) begin pc_sel = PC_JALR; wb_sel = WB_PC4; end
      OPC_BRANCH: pc_sel = PC_BRANCH;
      OPC_LOAD:   if (funct3 == F3_WORD) wb_sel = WB_MEM;
      OPC_STORE:  begin op_b = imm_s_w; is_store = (funct3 == F3_WORD); end
      OPC_OP_IMM: begin
        wb_sel = WB_ALU;
        case (funct3)
          F3_ADD:  alu_op = ALU_ADD;
          F3_SLT:  alu_op = ALU_SLT;
          F3_SLTU: alu_op = ALU_SLTU;
          F3_XOR:  alu_op = ALU_XOR;
          F3_OR:   alu_op = ALU_OR;
          F3_AND:  alu_op = ALU_AND;
          F3_SLL:  if (funct7 == F7_BASE) alu_op = ALU_SLL; else wb_sel = WB_NONE;
          F3_SR: begin
            if (funct7 == F7_BASE)     alu_op = ALU_SRL;
            else if (funct7 == F7_ALT) alu_op = ALU_SRA;
            else                       wb_sel = WB_NONE;
          end
          default: wb_sel = WB_NONE;
        endcase
      end
      OPC_OP: begin
        op_b = rs2_val;
        if (funct7 == F7_BASE) begin
          wb_sel = WB_ALU;
          case (funct3)
            F3_ADD:  alu_op = ALU_ADD;
            F3_SLL:  alu_op = ALU_SLL;
            F3_SLT:  alu_op = ALU_SLT;
            F3_SLTU: alu_op = ALU_SLTU;
            F3_XOR:  alu_op = ALU_XOR;
            F3_SR:   alu_op = ALU_SRL;
            F3_OR:   alu_op = ALU_OR;
            default: alu_op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          alu_op = ALU_SUB; wb_sel = WB_ALU;
        end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
          alu_op = ALU_SRA; wb_sel = WB_ALU;
`ifdef TOP_RISCV_MUL_EN
        end else if (funct7 == F7_MULDIV && funct3 == F3_ADD) begin
          alu_op = ALU_MUL; wb_sel = WB_ALU;
`endif
        end
      end
      default: ;
    endcase
  end

  assign op_a = op_a_pc ? pc_q : rs1_val;

  always_comb begin
    case (alu_op)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_SLL:   alu_res = op_a << op_b[4:0];
      ALU_SLT:   alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_res = {31'b0, op_a < op_b};
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SRL:   alu_res = op_a >> op_b[4:0];
      ALU_SRA:   alu_res = word_t'($signed(op_a) >>> op_b[4:0]);
      ALU_OR:    alu_res = op_a | op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_PASSB: alu_res = op_b;
`ifdef TOP_RISCV_MUL_EN
      ALU_MUL:   alu_res = op_a * op_b;
`endif
      default:   alu_res = '0;
    endcase
  end

  // Reserved branch funct3 values never take, so they fall through to PC + 4.
  always_comb begin
    case (funct3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_taken = (rs1_val < rs2_val);
      F3_BGEU: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    case (pc_sel)
      PC_BRANCH: pc_d = br_taken ? (pc_q + imm_b_w) : pc_plus4;
      PC_JAL:    pc_d = pc_q + imm_j_w;
      PC_JALR:   pc_d = alu_res & ~32'd1;
      default:   pc_d = pc_plus4;
    endcase
    pc_d[1:0] = 2'b00;
  end

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = mem_data;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_res;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign iadrr    = pc_q;
  assign daddr    = alu_res;
  assign data_out = rs2_val;
  assign mem_en   = is_store & ~rst;
endmodule

// File: tb/tb_top_riscv.sv
// Directed and random instruction stream for top_riscv, checked against an
// instruction-level model of the architectural state (registers, PC, memory).
module tb_top_riscv;
  logic        clk, rst;
  logic [31:0] iadrr, instr_in, daddr, data_out, mem_data;
  logic        mem_en;

  logic [31:0] dmem [64];
  logic [31:0] m_x [32];
  logic [31:0] m_mem [64];
  logic [31:0] m_pc;
  logic        e_store;
  logic [31:0] e_addr, e_data, e_pc;
  int          total = 0;
  int          bad = 0;

  top_riscv dut (
    .clk(clk), .rst(rst), .iadrr(iadrr), .instr_in(instr_in), .daddr(daddr),
    .data_out(data_out), .mem_data(mem_data), .mem_en(mem_en)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #500 clk = ~clk;

  assign mem_data = dmem[daddr[7:2]];
  always @(posedge clk) if (mem_en) dmem[daddr[7:2]] <= data_out;

  // encoders
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6F};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  // Reference model: one architectural instruction step.
  task automatic model_exec(input logic [31:0] ins);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] a, b, ii, si, bi, ui, ji, res, npc, addr;
    logic        wr, take;
    opc = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12];
    rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
    a = m_x[rs1]; b = m_x[rs2];
    ii = {{20{ins[31]}}, ins[31:20]};
    si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    bi = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    ui = {ins[31:12], 12'h000};
    ji = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    npc = m_pc + 32'd4; wr = 1'b0; res = '0; take = 1'b0;
    e_store = 1'b0; e_addr = '0; e_data = '0;
    case (opc)
      7'h37: begin wr = 1'b1; res = ui; end
      7'h17: begin wr = 1'b1; res = m_pc + ui; end
      7'h6F: begin wr = 1'b1; res = m_pc + 32'd4; npc = m_pc + ji; end
      7'h67: if (f3 == 3'd0) begin wr = 1'b1; res = m_pc + 32'd4; npc = (a + ii) & ~32'd1; end
      7'h63: begin
        case (f3)
          3'd0: take = (a == b);
          3'd1: take = (a != b);
          3'd4: take = (int'(a) < int'(b));
          3'd5: take = (int'(a) >= int'(b));
          3'd6: take = (a < b);
          3'd7: take = (a >= b);
          default: take = 1'b0;
        endcase
        if (take) npc = m_pc + bi;
      end
      7'h03: if (f3 == 3'd2) begin addr = a + ii; wr = 1'b1; res = m_mem[addr[7:2]]; end
      7'h23: if (f3 == 3'd2) begin
        addr = a + si; e_store = 1'b1; e_addr = addr; e_data = b; m_mem[addr[7:2]] = b;
      end
      7'h13: begin
        wr = 1'b1;
        case (f3)
          3'd0: res = a + ii;
          3'd2: res = (int'(a) < int'(ii)) ? 32'd1 : 32'd0;
          3'd3: res = (a < ii) ? 32'd1 : 32'd0;
          3'd4: res = a ^ ii;
          3'd6: res = a | ii;
          3'd7: res = a & ii;
          3'd1: if (f7 == 7'h00) res = a << ins[24:20]; else wr = 1'b0;
          default: begin
            if (f7 == 7'h00)      res = a >> ins[24:20];
            else if (f7 == 7'h20) res = 32'($signed(a) >>> ins[24:20]);
            else                  wr = 1'b0;
          end
        endcase
      end
      7'h33: begin
        if (f7 == 7'h00) begin
          wr = 1'b1;
          case (f3)
            3'd0: res = a + b;
            3'd1: res = a << b[4:0];
            3'd2: res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: res = (a < b) ? 32'd1 : 32'd0;
            3'd4: res = a ^ b;
            3'd5: res = a >> b[4:0];
            3'd6: res = a | b;
            default: res = a & b;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
          wr = 1'b1; res = a - b;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
          wr = 1'b1; res = 32'($signed(a) >>> b[4:0]);
`ifdef TOP_RISCV_MUL_EN
        end else if (f7 == 7'h01 && f3 == 3'd0) begin
          wr = 1'b1; res = a * b;
`endif
        end
      end
      default: ;
    endcase
    npc[1:0] = 2'b00;
    if (wr && rd != 5'd0) m_x[rd] = res;
    m_pc = npc;
  endtask

  // driver tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins);
    e_pc = m_pc;
    instr_in = ins;
    model_exec(ins);
    @(negedge clk);
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [31:0] ins);
    drive(ins);
    chk("iadrr", iadrr, e_pc);
    chk("mem_en", 32'(mem_en), 32'(e_store));
    if (e_store) begin
      chk("st_daddr", daddr, e_addr);
      chk("st_data", data_out, e_data);
    end
    commit();
  endtask

  // Presents "sw rN,0(x0)" without clocking so data_out shows register rN.
  task automatic check_reg(input logic [4:0] r, input logic [31:0] exp);
    instr_in = enc_s(12'h000, r, 5'd0, 3'b010);
    #1;
    chk($sformatf("x%0d", r), data_out, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_x[i] = '0;
    m_pc = '0;
  endtask

  function automatic logic [31:0] gen_rand();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    logic [31:0] ins;
    int          k;
    rd = 5'($urandom_range(0, 31)); rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31)); f3 = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    k = int'($urandom_range(0, 16)) - 8;
    case ($urandom_range(0, 9))
      0, 1, 2: begin
        if (f3 == 3'd1 || f3 == 3'd5) imm = {f7, imm[4:0]};
        ins = enc_i(imm, rs1, f3, rd, 7'h13);
      end
      3, 4: ins = enc_r(f7, rs2, rs1, f3, rd);
      5: ins = enc_u(20'($urandom), rd, ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17);
      6: ins = enc_s(12'(4 * $urandom_range(0, 15)), rs2, 5'd0, 3'b010);
      7: ins = enc_i(12'(4 * $urandom_range(0, 15)), 5'd0, 3'b010, rd, 7'h03);
      8: ins = enc_b(13'(k * 4), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), f3);
      default: begin
        if ($urandom_range(0, 1) == 0) ins = enc_j(21'(k * 4), rd);
        else ins = enc_i(12'(4 * $urandom_range(0, 63) + $urandom_range(0, 1)), 5'd0,
                         3'd0, rd, 7'h67);
      end
    endcase
    return ins;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) begin dmem[i] = '0; m_mem[i] = '0; end
    model_reset();
    rst = 1'b1;
    instr_in = enc_s(12'h010, 5'd0, 5'd0, 3'b010);

    // reset held for two cycles with a store presented
    repeat (2) begin
      @(negedge clk);
      chk("rst_iadrr", iadrr, 32'h0);
      chk("rst_mem_en", 32'(mem_en), 32'h0);
      chk("rst_daddr", daddr, 32'h10);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    step(32'h0000_0013); step(32'h0000_0013); step(32'h0000_0013);
    chk("pc_after_3", iadrr, 32'hC);

    // ALU
    step(32'h0050_0093); step(32'h0070_0113); step(32'h0020_81B3);
    check_reg(5'd3, 32'd12);
    step(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd5));
    check_reg(5'd5, 32'hFFFF_FFFE);
    step(enc_u(20'h80000, 5'd6, 7'h37));
    step(enc_i(12'd4, 5'd0, 3'd0, 5'd7, 7'h13));
    step(enc_r(7'h20, 5'd7, 5'd6, 3'd5, 5'd8));
    step(enc_i({7'h20, 5'd4}, 5'd6, 3'd5, 5'd9, 7'h13));
    step(enc_r(7'h00, 5'd7, 5'd6, 3'd5, 5'd11));
    step(enc_r(7'h00, 5'd1, 5'd5, 3'd2, 5'd12));
    step(enc_r(7'h00, 5'd1, 5'd5, 3'd3, 5'd13));
    check_reg(5'd8, 32'hF800_0000);
    check_reg(5'd9, 32'hF800_0000);
    check_reg(5'd11, 32'h0800_0000);
    check_reg(5'd12, 32'd1);
    check_reg(5'd13, 32'd0);

    // store then dependent load
    drive(32'h0030_2423);
    chk("sw_daddr", daddr, 32'd8);
    chk("sw_data", data_out, 32'd12);
    chk("sw_mem_en", 32'(mem_en), 32'd1);
    commit();
    drive(32'h0080_2203);
    chk("lw_mem_en", 32'(mem_en), 32'd0);
    commit();
    check_reg(5'd4, 32'd12);

    // branches and jumps
    step(enc_i(12'h010, 5'd0, 3'd0, 5'd0, 7'h67));
    chk("jalr_to_10", iadrr, 32'h10);
    step(enc_b(13'd8, 5'd1, 5'd1, 3'd0));
    chk("beq_taken", iadrr, 32'h18);
    step(enc_i(12'h010, 5'd0, 3'd0, 5'd0, 7'h67));
    step(enc_b(13'd8, 5'd1, 5'd1, 3'd1));
    chk("bne_not_taken", iadrr, 32'h14);
    step(enc_i(12'h020, 5'd0, 3'd0, 5'd0, 7'h67));
    step(enc_j(21'h20, 5'd1));
    chk("jal_pc", iadrr, 32'h40);
    check_reg(5'd1, 32'h24);
    step(enc_i(12'h041, 5'd0, 3'd0, 5'd10, 7'h13));
    step(enc_i(12'h000, 5'd10, 3'd0, 5'd0, 7'h67));
    chk("jalr_lsb", iadrr, 32'h40);

    // x0 and illegal encodings
    step(32'h0050_0013);
    check_reg(5'd0, 32'd0);
    drive(32'h0000_02FF);
    chk("ill_mem_en", 32'(mem_en), 32'd0);
    commit();
    chk("ill_pc", iadrr, e_pc + 32'd4);
    check_reg(5'd5, 32'hFFFF_FFFE);
    step(enc_i(12'h008, 5'd0, 3'd0, 5'd5, 7'h03));
    check_reg(5'd5, 32'hFFFF_FFFE);
    drive(enc_s(12'h008, 5'd3, 5'd0, 3'd0));
    chk("sb_mem_en", 32'(mem_en), 32'd0);
    commit();

    step(enc_i(12'd7, 5'd0, 3'd0, 5'd14, 7'h13));
    step(enc_i(12'd6, 5'd0, 3'd0, 5'd15, 7'h13));
    step(enc_r(7'h01, 5'd15, 5'd14, 3'd0, 5'd16));
`ifdef TOP_RISCV_MUL_EN
    check_reg(5'd16, 32'd42);
`else
    check_reg(5'd16, 32'd0);
`endif

    // random stream against the model
    for (int n = 0; n < 400; n++) step(gen_rand());
    for (int r = 0; r < 32; r++) check_reg(5'(r), m_x[r]);

    // reset asserted in the middle of a store cycle
    step(enc_i(12'h5A5, 5'd0, 3'd0, 5'd3, 7'h13));
    instr_in = enc_s(12'h080, 5'd3, 5'd0, 3'b010);
    @(negedge clk);
    chk("mr_mem_en_pre", 32'(mem_en), 32'd1);
    #100 rst = 1'b1;
    #1;
    chk("mr_mem_en", 32'(mem_en), 32'd0);
    chk("mr_iadrr", iadrr, 32'h0);
    for (int r = 0; r < 32; r++) check_reg(5'(r), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    step(32'h0000_0013);
    step(32'h0000_0013);
    chk("mr_pc", iadrr, 32'h8);
    step(enc_i(12'h080, 5'd0, 3'b010, 5'd4, 7'h03));
    check_reg(5'd4, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
